// File: rtl/adder_sweep_checker_if.sv
// Handshake and result bundle between the sweep checker and the 2-bit adder under test.
// master = checker side (drives operands/status), slave = environment side (drives start and the sum).
interface adder_sweep_checker_if;
  logic       start;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic [2:0] y_in;
  logic       busy;
  logic       done;
  logic [4:0] err_cnt;
  logic [6:0] first_err;
  logic       pass;

  modport master (
    input  start, y_in,
    output a_out, b_out, busy, done, err_cnt, first_err, pass
  );

  modport slave (
    output start, y_in,
    input  a_out, b_out, busy, done, err_cnt, first_err, pass
  );
endinterface

// File: rtl/adder_sweep_checker.sv
// Drives all 16 operand pairs into an external 2-bit adder, holds each HOLD cycles, then compares y_in.
// Sweep length is 16*(HOLD+1) cycles; start is ignored while busy; all outputs decode from registered state.
module adder_sweep_checker #(
  parameter int unsigned HOLD = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  adder_sweep_checker_if.master  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [6:0] first_err_q, first_err_d;
  logic [2:0] exp_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      hold_q      <= 4'd0;
      err_cnt_q   <= 5'd0;
      first_err_q <= 7'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  // Operands are idx itself in SAMPLE, so the reference sum comes straight from idx.
  assign exp_sum = {1'b0, idx_q[3:2]} + {1'b0, idx_q[1:0]};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = DRIVE;
          idx_d       = 4'd0;
          hold_d      = 4'd0;
          err_cnt_d   = 5'd0;
          first_err_d = 7'd0;
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = SAMPLE;
          hold_d  = 4'd0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (bus.y_in != exp_sum) begin
          if (err_cnt_q != 5'd31) begin
            err_cnt_d = err_cnt_q + 5'd1;
          end
          if (err_cnt_q == 5'd0) begin
            first_err_d = {idx_q, bus.y_in};
          end
        end
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic active;
  assign active        = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.busy      = active;
  assign bus.done      = (state_q == DONE);
  assign bus.a_out     = active ? idx_q[3:2] : 2'd0;
  assign bus.b_out     = active ? idx_q[1:0] : 2'd0;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.first_err = first_err_q;
  assign bus.pass      = (state_q == DONE) && (err_cnt_q == 5'd0);

endmodule

// File: doc/adder_sweep_checker.md
ADDER_SWEEP_CHECKER -- requirements
Module: adder_sweep_checker

Interface
REQ-001 Parameter HOLD, default 1, legal range 1..15: number of cycles each operand pair is driven before y_in is sampled.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a full sweep; sampled on rising clk edge.
REQ-005 a_out  output  2  operand a driven to the downstream 2-bit adder.
REQ-006 b_out  output  2  operand b driven to the downstream 2-bit adder.
REQ-007 y_in  input  3  sum returned by the adder, combinational w.r.t. a_out/b_out.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high from sweep completion until the next start is accepted or reset.
REQ-010 err_cnt  output  5  number of mismatching pairs in the current/last sweep.
REQ-011 first_err  output  7  {a, b, y_in} of the first mismatch in the sweep; 0 if none.
REQ-012 pass  output  1  done AND (err_cnt == 0).

Function
REQ-013 FSM states IDLE, DRIVE, SAMPLE, DONE; 4-bit pair index idx, 4-bit hold counter.
REQ-014 IDLE: busy=0, done=0, a_out=b_out=0; start=1 -> DRIVE, idx=0, err_cnt=0, first_err=0.
REQ-015 DRIVE: a_out=idx[3:2], b_out=idx[1:0]; stays exactly HOLD cycles, then -> SAMPLE.
REQ-016 SAMPLE: one cycle, operands unchanged; expected = {1'b0,a_out} + {1'b0,b_out}, 3-bit result, no overflow possible.
REQ-017 SAMPLE mismatch (y_in != expected): err_cnt increments, saturating at 31; if err_cnt was 0, first_err <= {a_out, b_out, y_in}.
REQ-018 SAMPLE exit: idx==15 -> DONE; else idx <= idx+1 (no wrap beyond 15) -> DRIVE.
REQ-019 Sweep order: a-major, b-minor: (0,0),(0,1),...,(0,3),(1,0),...,(3,3).
REQ-020 Each pair occupies HOLD+1 cycles; DONE entered 16*(HOLD+1) rising edges after the edge that accepted start.
REQ-021 DONE: busy=0, done=1, operands return to 0, err_cnt/first_err held; start=1 -> DRIVE with counters cleared as in IDLE.
REQ-022 start is ignored in DRIVE and SAMPLE; busy=1 in both.
REQ-023 start held continuously: sweeps run back-to-back, done high exactly one cycle between them.
REQ-024 All outputs registered or decoded from registered state only; no combinational path y_in -> any output.

Reset
REQ-025 rst=1 forces immediately, without clock: state IDLE, idx=0, hold counter=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err=0.
REQ-026 rst asserted mid-sweep aborts the sweep; no partial result retained; first start after rst release begins at pair (0,0).

Verification
REQ-027 HOLD=1, correct adder model, start pulse 1 cycle -> 16 pairs in order, done rises 32 edges after accepting edge, err_cnt=0, first_err=0, pass=1.
REQ-028 HOLD=1, adder y[0] stuck at 0 -> err_cnt=8 (odd sums), first_err=7'b00_01_000 (a=0,b=1,y=0), pass=0.
REQ-029 HOLD=3, correct adder -> each pair held 3 cycles before sample, done 64 edges after start; start pulse at cycle 10 of sweep has no effect.
REQ-030 Async rst asserted between clock edges during pair (1,1) -> busy/a_out/b_out/err_cnt go 0 before next edge; new start yields full 32-cycle sweep from (0,0).
REQ-031 start held high for 3 sweeps with HOLD=1, faulty model on odd sums -> done high one cycle every 33 cycles, err_cnt cleared to 0 then reaches 8 each sweep.
REQ-032 Bench checks a_out+b_out vs y_in independently and asserts pass matches its own tally at every done.
